lsu_64i: RTL and testbench

//  RV64I load/store unit consuming the lsu_op bus from the decode stage.

---
 rtl/lsu_64i.sv | 181 ++++++++++++++++++
 tb/tb_lsu_64i.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_64i.sv
// RV64I load/store unit: alignment check, strobe/lane build, req/gnt + rvalid
// data-bus handshake and load extension, with one access in flight.
module lsu_64i #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [6:0]        lsu_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [63:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              data_req,
  input  logic              data_gnt,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [7:0]        data_wstrb,
  output logic [63:0]       data_wdata,
  input  logic              data_rvalid,
  input  logic [63:0]       data_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              busy
);

  if (TIMEOUT != 0) begin : g_timeout_unsupported
    $error("lsu_64i: TIMEOUT must be 0");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_EXC  = 3'd4;

  logic [2:0]        state;
  logic              we_q;
  logic [3:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [7:0]        strb_q;
  logic [63:0]       wdata_q;
  logic [63:0]       ld_q;
  logic              squash_q;

  logic        op_en;
  logic        op_we;
  logic [3:0]  op_size;
  logic        size_ok;
  logic        misal;
  logic [7:0]  strb_d;
  logic [63:0] wdata_d;
  logic [63:0] lane;
  logic [63:0] ld_ext;

  assign op_en   = lsu_op[6];
  assign op_we   = lsu_op[5];
  assign op_size = lsu_op[4:1];

  // Decode the incoming op: legality, byte strobes and lane-replicated store data.
  always_comb begin
    size_ok = (op_size == 4'b0001) || (op_size == 4'b0010) ||
              (op_size == 4'b0100) || (op_size == 4'b1000);
    misal   = (op_size[1] & ex_addr[0]) |
              (op_size[2] & (|ex_addr[1:0])) |
              (op_size[3] & (|ex_addr[2:0]));
    strb_d  = '0;
    wdata_d = ex_wdata;
    case (op_size)
      4'b0001: begin
        strb_d  = 8'b0000_0001 << ex_addr[2:0];
        wdata_d = {8{ex_wdata[7:0]}};
      end
      4'b0010: begin
        strb_d  = 8'b0000_0011 << ex_addr[2:0];
        wdata_d = {4{ex_wdata[15:0]}};
      end
      4'b0100: begin
        strb_d  = 8'b0000_1111 << ex_addr[2:0];
        wdata_d = {2{ex_wdata[31:0]}};
      end
      4'b1000: begin
        strb_d  = 8'hFF;
        wdata_d = ex_wdata;
      end
      default: begin
        strb_d  = '0;
        wdata_d = ex_wdata;
      end
    endcase
    if (!op_we) strb_d = '0;
  end

  // Select the addressed lane of the response and sign/zero extend it.
  always_comb begin
    lane = data_rdata >> {addr_q[2:0], 3'b000};
    case (size_q)
      4'b0001: ld_ext = uns_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      4'b0010: ld_ext = uns_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      4'b0100: ld_ext = uns_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: ld_ext = data_rdata;
    endcase
  end

  // Control FSM and op capture; a flush at or after grant lets the bus finish but
  // marks the op squashed so its writeback pulse is withheld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      rd_q     <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      ld_q     <= '0;
      squash_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid && op_en) begin
            we_q     <= op_we;
            size_q   <= op_size;
            uns_q    <= lsu_op[0];
            addr_q   <= ex_addr;
            rd_q     <= ex_rd;
            strb_q   <= strb_d;
            wdata_q  <= wdata_d;
            squash_q <= 1'b0;
            state    <= (!size_ok || misal) ? S_EXC : S_REQ;
          end
        end
        S_REQ: begin
          if (data_gnt) begin
            squash_q <= squash_q | flush;
            state    <= we_q ? S_DONE : S_RESP;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_RESP: begin
          if (flush) squash_q <= 1'b1;
          if (data_rvalid) begin
            ld_q  <= ld_ext;
            state <= (squash_q || flush) ? S_IDLE : S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_EXC:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus and writeback outputs, held at zero outside the states that own them.
  always_comb begin
    ex_ready     = (state == S_IDLE);
    busy         = (state != S_IDLE);
    data_req     = (state == S_REQ);
    data_we      = data_req & we_q;
    data_addr    = data_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    data_wstrb   = data_req ? strb_q : '0;
    data_wdata   = (data_req && we_q) ? wdata_q : '0;
    wb_valid     = (state == S_DONE) && !squash_q && !flush;
    wb_we        = wb_valid & ~we_q;
    wb_rd        = wb_valid ? rd_q : '0;
    wb_data      = (wb_valid && !we_q) ? ld_q : '0;
    misalign_exc = (state == S_EXC) && !flush;
    exc_addr     = misalign_exc ? addr_q : '0;
  end

endmodule

// File: tb/tb_lsu_64i.sv
// Directed bench for lsu_64i: table of single transactions plus hand-written
// sequences for gnt stall, flush and reset-abandon cases.
module tb_lsu_64i;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  lsu_op;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [63:0] data_addr;
  logic [7:0]  data_wstrb;
  logic [63:0] data_wdata;
  logic        data_rvalid;
  logic [63:0] data_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign_exc;
  logic [63:0] exc_addr;
  logic        busy;

  always #5 clk = ~clk;

  lsu_64i #(.ADDR_W(64), .TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .lsu_op(lsu_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .flush(flush), .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .exc_addr(exc_addr), .busy(busy)
  );

  // {ram_en, ram_we, size D W H B, unsigned}
  localparam logic [6:0] LB  = 7'b10_0001_0;
  localparam logic [6:0] LBU = 7'b10_0001_1;
  localparam logic [6:0] LH  = 7'b10_0010_0;
  localparam logic [6:0] LHU = 7'b10_0010_1;
  localparam logic [6:0] LW  = 7'b10_0100_0;
  localparam logic [6:0] LWU = 7'b10_0100_1;
  localparam logic [6:0] LD  = 7'b10_1000_0;
  localparam logic [6:0] SB  = 7'b11_0001_0;
  localparam logic [6:0] SH  = 7'b11_0010_0;
  localparam logic [6:0] SW  = 7'b11_0100_0;
  localparam logic [6:0] SD  = 7'b11_1000_0;

  typedef struct {
    logic [6:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        exc;
    logic [7:0]  strb;
    logic [63:0] bwdata;
    logic [63:0] wbdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept(input logic [6:0] op, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rd);
    tick();
    ex_valid = 1'b1; lsu_op = op; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [63:0] exp_addr;
    exp_addr = {v.addr[63:3], 3'b000};
    accept(v.op, v.addr, v.wdata, v.rd);
    if (v.exc) begin
      chk($sformatf("v%0d_exc", i), {63'd0, misalign_exc}, 64'd1);
      chk($sformatf("v%0d_exc_addr", i), exc_addr, v.addr);
      chk($sformatf("v%0d_exc_noreq", i), {63'd0, data_req}, 64'd0);
      tick();
      chk($sformatf("v%0d_exc_pulse", i), {62'd0, misalign_exc, data_req}, 64'd0);
      chk($sformatf("v%0d_exc_idle", i), {63'd0, busy}, 64'd0);
    end else begin
      chk($sformatf("v%0d_req", i), {63'd0, data_req}, 64'd1);
      chk($sformatf("v%0d_ready_busy", i), {63'd0, ex_ready}, 64'd0);
      chk($sformatf("v%0d_we", i), {63'd0, data_we}, {63'd0, v.op[5]});
      chk($sformatf("v%0d_addr", i), data_addr, exp_addr);
      chk($sformatf("v%0d_strb", i), {56'd0, data_wstrb}, {56'd0, v.strb});
      if (v.op[5]) chk($sformatf("v%0d_bwdata", i), data_wdata, v.bwdata);
      data_gnt = 1'b1;
      tick();
      data_gnt = 1'b0;
      if (!v.op[5]) begin
        chk($sformatf("v%0d_resp_state", i), {62'd0, data_req, wb_valid}, 64'd0);
        data_rvalid = 1'b1; data_rdata = v.rdata;
        tick();
        data_rvalid = 1'b0; data_rdata = '0;
      end
      chk($sformatf("v%0d_wb_valid", i), {63'd0, wb_valid}, 64'd1);
      chk($sformatf("v%0d_wb_we", i), {63'd0, wb_we}, {63'd0, ~v.op[5]});
      chk($sformatf("v%0d_wb_rd", i), {59'd0, wb_rd}, {59'd0, v.rd});
      if (!v.op[5]) chk($sformatf("v%0d_wb_data", i), wb_data, v.wbdata);
      tick();
      chk($sformatf("v%0d_after", i), {62'd0, wb_valid, ex_ready}, 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; lsu_op = '0; ex_addr = '0; ex_wdata = '0;
    ex_rd = '0; flush = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;

    vecs[0]  = '{LB,  64'h1003, 64'h0, 5'd1,  64'h11223344_80667788, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{LHU, 64'h2006, 64'h0, 5'd2,  64'h8001_2222_3333_4444, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_8001};
    vecs[2]  = '{LH,  64'h2006, 64'h0, 5'd3,  64'h8001_2222_3333_4444, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[3]  = '{LD,  64'h3000, 64'h0, 5'd4,  64'hDEAD_BEEF_0123_4567, 1'b0, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[4]  = '{LW,  64'h3004, 64'h0, 5'd5,  64'h8765_4321_0000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
    vecs[5]  = '{LWU, 64'h3004, 64'h0, 5'd6,  64'h8765_4321_0000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8765_4321};
    vecs[6]  = '{LBU, 64'h3007, 64'h0, 5'd7,  64'hF000_0000_0000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_00F0};
    vecs[7]  = '{SB,  64'h4005, 64'hAAAA_AAAA_AAAA_AA5C, 5'd8, 64'h0, 1'b0, 8'h20, 64'h5C5C_5C5C_5C5C_5C5C, 64'h0};
    vecs[8]  = '{SH,  64'h4002, 64'h1111_2222_3333_BEEF, 5'd9, 64'h0, 1'b0, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0};
    vecs[9]  = '{SW,  64'h100C, 64'h0000_0000_1234_5678, 5'd10, 64'h0, 1'b0, 8'hF0, 64'h1234_5678_1234_5678, 64'h0};
    vecs[10] = '{SD,  64'h5008, 64'h0102_0304_0506_0708, 5'd11, 64'h0, 1'b0, 8'hFF, 64'h0102_0304_0506_0708, 64'h0};
    vecs[11] = '{LW,  64'h1002, 64'h0, 5'd12, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
    vecs[12] = '{SD,  64'h5004, 64'h0, 5'd13, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
    vecs[13] = '{LH,  64'h2001, 64'h0, 5'd14, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
    vecs[14] = '{7'b10_0011_0, 64'h6000, 64'h0, 5'd15, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
    vecs[15] = '{7'b10_0000_0, 64'h6008, 64'h0, 5'd16, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0};

    // reset state
    tick(); tick();
    chk("rst_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_outs", {58'd0, data_req, data_we, wb_valid, wb_we, misalign_exc, busy}, 64'd0);
    chk("rst_buses", data_addr | data_wdata | wb_data | exc_addr | {56'd0, data_wstrb} | {59'd0, wb_rd}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // ram_en=0 is ignored
    accept(7'b01_0100_0, 64'h7000, 64'h0, 5'd1);
    chk("noen_idle", {62'd0, busy, data_req}, 64'd0);

    // sw with gnt delayed 3 cycles: request fields stable throughout
    accept(SW, 64'h100C, 64'h0000_0000_1234_5678, 5'd20);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_req", c), {63'd0, data_req}, 64'd1);
      chk($sformatf("stall%0d_addr", c), data_addr, 64'h1008);
      chk($sformatf("stall%0d_strb", c), {56'd0, data_wstrb}, 64'hF0);
      chk($sformatf("stall%0d_wdata", c), data_wdata, 64'h1234_5678_1234_5678);
      chk($sformatf("stall%0d_nowb", c), {63'd0, wb_valid}, 64'd0);
      tick();
    end
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    chk("stall_wb", {61'd0, wb_valid, wb_we, data_req}, 64'b100);
    chk("stall_wb_rd", {59'd0, wb_rd}, 64'd20);
    tick();

    // load flushed in RESP, rvalid two cycles later
    accept(LD, 64'h8000, 64'h0, 5'd21);
    data_gnt = 1'b1; tick(); data_gnt = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flresp_wait", {62'd0, busy, wb_valid}, 64'b10);
    tick();
    data_rvalid = 1'b1; data_rdata = 64'h55; tick(); data_rvalid = 1'b0;
    chk("flresp_nowb", {63'd0, wb_valid}, 64'd0);
    chk("flresp_idle", {63'd0, ex_ready}, 64'd1);
    tick();
    chk("flresp_nowb2", {63'd0, wb_valid}, 64'd0);

    // flush in REQ before gnt drops the request
    accept(LW, 64'h8004, 64'h0, 5'd22);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flreq_drop", {61'd0, data_req, busy, wb_valid}, 64'd0);

    // flush in the gnt cycle of a store: bus completes, pulse withheld
    accept(SD, 64'h9000, 64'h1, 5'd23);
    data_gnt = 1'b1; flush = 1'b1; tick(); data_gnt = 1'b0; flush = 1'b0;
    chk("flgnt_nowb", {62'd0, wb_valid, busy}, 64'b01);
    tick();
    chk("flgnt_idle", {62'd0, wb_valid, busy}, 64'd0);

    // flush during DONE and during EXC suppresses those pulses
    accept(SB, 64'h9001, 64'h7, 5'd24);
    data_gnt = 1'b1; tick(); data_gnt = 1'b0;
    flush = 1'b1; #1;
    chk("fldone_nowb", {63'd0, wb_valid}, 64'd0);
    tick(); flush = 1'b0;
    accept(LD, 64'h9003, 64'h0, 5'd25);
    flush = 1'b1; #1;
    chk("flexc_noexc", {63'd0, misalign_exc}, 64'd0);
    tick(); flush = 1'b0;
    chk("flexc_idle", {63'd0, busy}, 64'd0);

    // reset during REQ abandons the access; later rvalid ignored
    accept(LW, 64'hA000, 64'h0, 5'd26);
    chk("rstreq_req", {63'd0, data_req}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstreq_drop", {61'd0, data_req, busy, ex_ready}, 64'b001);
    data_rvalid = 1'b1; data_rdata = 64'hFFFF; tick(); data_rvalid = 1'b0;
    chk("rstreq_stray", {61'd0, wb_valid, busy, misalign_exc}, 64'd0);
    tick();
    chk("rstreq_stray2", {62'd0, wb_valid, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
